// File: rtl/axi_mem_master.sv
// AXI4 initiator: single-request port to AXI read bursts / single-beat writes, one transaction in flight.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN to force-complete stalled transactions with error.
`timescale 1ns/1ps
module axi_mem_master #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clock,
   input  logic        reset,
   // request side
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [7:0]  req_len,
   input  logic [2:0]  req_size,
   input  logic [1:0]  req_burst,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   // read return side
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [31:0] rd_data,
   output logic        rd_last,
   output logic        rd_err,
   // write completion
   output logic        wr_done,
   output logic        wr_err,
   // AXI read address
   output logic        arvalid,
   input  logic        arready,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   // AXI read data
   input  logic        rvalid,
   output logic        rready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   // AXI write address
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   // AXI write data
   output logic        wvalid,
   input  logic        wready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   // AXI write response
   input  logic        bvalid,
   output logic        bready,
   input  logic [1:0]  bresp
);

   typedef enum logic [2:0] {
      IDLE,
      AR,
      R,
      AWW,
      B
`ifdef AXI_MASTER_TIMEOUT_EN
      , TERR
`endif
   } state_t;

   state_t      state_q, state_d;

   logic        arvalid_q, arvalid_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q,  wvalid_d;
   logic        bready_q,  bready_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q,  w_done_d;
   logic        wr_done_q, wr_done_d;
   logic        wr_err_q,  wr_err_d;

   logic [31:0] araddr_q,  araddr_d;
   logic [7:0]  arlen_q,   arlen_d;
   logic [2:0]  arsize_q,  arsize_d;
   logic [1:0]  arburst_q, arburst_d;
   logic [31:0] awaddr_q,  awaddr_d;
   logic [2:0]  awsize_q,  awsize_d;
   logic [31:0] wdata_q,   wdata_d;
   logic [3:0]  wstrb_q,   wstrb_d;

   logic        hs_ar, hs_r, hs_aw, hs_w, hs_b;
   logic        aw_now, w_now;

`ifdef AXI_MASTER_TIMEOUT_EN
   logic [31:0] cnt_q, cnt_d;
`endif

   assign hs_ar = arvalid_q & arready;
   assign hs_r  = (state_q == R) & rvalid & rd_ready;
   assign hs_aw = awvalid_q & awready;
   assign hs_w  = wvalid_q & wready;
   assign hs_b  = bready_q & bvalid;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         arvalid_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         wr_done_q <= 1'b0;
         wr_err_q  <= 1'b0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
         arburst_q <= '0;
         awaddr_q  <= '0;
         awsize_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
`ifdef AXI_MASTER_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         arvalid_q <= arvalid_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         wr_done_q <= wr_done_d;
         wr_err_q  <= wr_err_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         arsize_q  <= arsize_d;
         arburst_q <= arburst_d;
         awaddr_q  <= awaddr_d;
         awsize_q  <= awsize_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
`ifdef AXI_MASTER_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      arvalid_d = arvalid_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      wr_done_d = 1'b0;
      wr_err_d  = 1'b0;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      arsize_d  = arsize_q;
      arburst_d = arburst_q;
      awaddr_d  = awaddr_q;
      awsize_d  = awsize_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      aw_now    = aw_done_q | hs_aw;
      w_now     = w_done_q | hs_w;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_write) begin
                  state_d   = AWW;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  awaddr_d  = req_addr;
                  awsize_d  = req_size;
                  wdata_d   = req_wdata;
                  wstrb_d   = req_wstrb;
               end else begin
                  state_d   = AR;
                  arvalid_d = 1'b1;
                  araddr_d  = req_addr;
                  arlen_d   = req_len;
                  arsize_d  = req_size;
                  arburst_d = req_burst;
               end
            end
         end
         AR: begin
            if (hs_ar) begin
               arvalid_d = 1'b0;
               state_d   = R;
            end
         end
         R: begin
            // rlast alone terminates the burst; beat count is not tracked
            if (hs_r && rlast) state_d = IDLE;
         end
         AWW: begin
            if (hs_aw) awvalid_d = 1'b0;
            if (hs_w)  wvalid_d  = 1'b0;
            aw_done_d = aw_now;
            w_done_d  = w_now;
            if (aw_now && w_now) begin
               bready_d = 1'b1;
               state_d  = B;
            end
         end
         B: begin
            if (hs_b) begin
               bready_d  = 1'b0;
               wr_done_d = 1'b1;
               wr_err_d  = (bresp != 2'b00);
               state_d   = IDLE;
            end
         end
`ifdef AXI_MASTER_TIMEOUT_EN
         TERR: begin
            if (rd_ready) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase

`ifdef AXI_MASTER_TIMEOUT_EN
      // Watchdog overrides the normal transition once the idle budget is spent.
      cnt_d = '0;
      if (state_q == AR || state_q == R || state_q == AWW || state_q == B) begin
         if (hs_ar || hs_r || hs_aw || hs_w || hs_b) begin
            cnt_d = '0;
         end else if (cnt_q == TIMEOUT - 1) begin
            arvalid_d = 1'b0;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            if (state_q == AR || state_q == R) begin
               state_d = TERR;
            end else begin
               wr_done_d = 1'b1;
               wr_err_d  = 1'b1;
               state_d   = IDLE;
            end
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end
`endif
   end

   assign req_ready = (state_q == IDLE);
   assign rready    = (state_q == R) & rd_ready;
   assign wr_done   = wr_done_q;
   assign wr_err    = wr_err_q;

`ifdef AXI_MASTER_TIMEOUT_EN
   assign rd_valid = ((state_q == R) & rvalid) | (state_q == TERR);
   assign rd_data  = (state_q == TERR) ? '0 : rdata;
   assign rd_last  = ((state_q == R) & rlast) | (state_q == TERR);
   assign rd_err   = ((state_q == R) & (rresp != 2'b00)) | (state_q == TERR);
`else
   assign rd_valid = (state_q == R) & rvalid;
   assign rd_data  = rdata;
   assign rd_last  = (state_q == R) & rlast;
   assign rd_err   = (state_q == R) & (rresp != 2'b00);
`endif

   assign arvalid = arvalid_q;
   assign araddr  = araddr_q;
   assign arlen   = arlen_q;
   assign arsize  = arsize_q;
   assign arburst = arburst_q;

   assign awvalid = awvalid_q;
   assign awaddr  = awaddr_q;
   assign awlen   = 8'd0;
   assign awsize  = awsize_q;
   assign awburst = 2'b01;

   assign wvalid  = wvalid_q;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wlast   = 1'b1;

   assign bready  = bready_q;

endmodule
